periph_arb: RTL and testbench
=============================

PERIPH_ARB -- requirements
Module: periph_arb

Interface
REQ-001 SHALL have parameter QUANTUM, default 4: maximum consecutive grants to one master while the other master is waiting (legal range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0200_0000: peripheral window base; only bits [31:16] are compared.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port m_req_i, input, [1:0]: per-master request.
REQ-006 SHALL have port m_we_i, input, [1:0]: per-master write enable.
REQ-007 SHALL have port m_be_i, input, [1:0][3:0]: per-master byte enables.
REQ-008 SHALL have port m_addr_i, input, [1:0][31:0]: per-master address.
REQ-009 SHALL have port m_wdata_i, input, [1:0][31:0]: per-master write data.
REQ-010 SHALL have port m_gnt_o, output, [1:0]: per-master grant, one-hot or zero.
REQ-011 SHALL have port m_rvalid_o, output, [1:0]: per-master response valid.
REQ-012 SHALL have port m_rdata_o, output, 32: response data, shared by both masters.
REQ-013 SHALL have port m_err_o, output, [1:0]: per-master decode error; qualified by m_rvalid_o.
REQ-014 SHALL have port s_req_o, output, 1: peripheral request.
REQ-015 SHALL have port s_we_o, output, 1: peripheral write enable.
REQ-016 SHALL have port s_be_o, output, 4: peripheral byte enables.
REQ-017 SHALL have port s_addr_o, output, 32: peripheral address.
REQ-018 SHALL have port s_wdata_o, output, 32: peripheral write data.
REQ-019 SHALL have port s_rdata_i, input, 32: peripheral read data, valid exactly one cycle after s_req_o.

Function
REQ-020 SHALL form m_gnt_o combinationally in the same cycle as m_req_i; s_req_o/we/be/addr/wdata SHALL mux the granted master's inputs combinationally; s_* are don't-care when no grant is issued.
REQ-021 SHALL accept at most one transaction per cycle; back-to-back grants every cycle are allowed.
REQ-022 SHALL maintain state: owner (1 bit, last granted master), run (4 bits, consecutive grants to owner), rsp_vld (1 bit), rsp_id (1 bit), rsp_err (1 bit).
REQ-023 Single requester: it SHALL be granted immediately, regardless of run.
REQ-024 Both requesting, run < QUANTUM: owner SHALL be granted; both requesting, run >= QUANTUM: the non-owner SHALL be granted.
REQ-025 On a grant to the owner, run SHALL saturating-increment (saturate at 15); on a grant to the non-owner, owner SHALL flip and run SHALL become 1; with no grant, owner and run SHALL hold.
REQ-026 QUANTUM=1 SHALL yield strict alternation under continuous contention.
REQ-027 Every grant (read or write) SHALL produce exactly one m_rvalid_o pulse to the same master in the following cycle; rsp_vld/rsp_id SHALL be registered at grant.
REQ-028 m_rdata_o SHALL equal s_rdata_i when the response is forwarded and SHALL equal 0 when rsp_err=1; for writes the data content is unspecified but valid-timed.
REQ-029 A new grant SHALL be allowed in the same cycle as the rvalid of the previous grant (full pipelining, no bubble).

Reset
REQ-030 While rst_i=1: m_gnt_o=0, m_rvalid_o=0, m_err_o=0, s_req_o=0, m_rdata_o=0; owner=0, run=0, rsp_vld=0.
REQ-031 A transaction granted in the cycle rst_i rises SHALL have its response dropped; no m_rvalid_o SHALL occur in the cycle after reset deasserts.
REQ-032 First contention after reset SHALL grant master 0 (owner=0, run=0 < QUANTUM).

Configuration
REQ-033 Macro PERIPH_ARB_DECODE_ERR_EN defined: a granted request with addr[31:16] != BASE_ADDR[31:16] SHALL NOT assert s_req_o; next cycle m_rvalid_o and m_err_o SHALL assert for that master with m_rdata_o=0; the request SHALL count for arbitration as normal.
REQ-034 Macro undefined: all granted requests SHALL be forwarded, m_err_o SHALL be constant 0, and no comparator logic SHALL be present.

Verification
REQ-035 Reset: hold rst_i 3 cycles with m_req_i=2'b11 -> all outputs 0; first post-reset cycle grants m0.
REQ-036 Contention, QUANTUM=4, both requesting continuously for 10 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0.
REQ-037 Pipelined reads: m1 reads three times on consecutive cycles, s_rdata_i = 32'hA, B, C -> m_rvalid_o[1] high 3 cycles, m_rdata_o = A, B, C.
REQ-038 Mixed: m0 write to 32'h0200_0004 then m1 read in the next cycle -> m_rvalid_o[0] in cycle 1 and m_rvalid_o[1] in cycle 2, no overlap.
REQ-039 DECODE_ERR_EN: m0 read 32'h0300_0000 -> s_req_o=0, next cycle m_rvalid_o[0]=1, m_err_o[0]=1, m_rdata_o=0; macro off -> forwarded, m_err_o=0.
REQ-040 Reset mid-op: assert rst_i in the grant cycle of an m0 read -> no m_rvalid_o[0] afterwards.

Source files
------------

// File: rtl/periph_arb.sv
// Two-master round-robin arbiter with a quantum, in front of a single-cycle peripheral.
// Optional address-window decode errors are enabled by defining PERIPH_ARB_DECODE_ERR_EN.
module periph_arb #(
  parameter int          QUANTUM   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       m_req_i,
  input  logic [1:0]       m_we_i,
  input  logic [1:0][3:0]  m_be_i,
  input  logic [1:0][31:0] m_addr_i,
  input  logic [1:0][31:0] m_wdata_i,
  output logic [1:0]       m_gnt_o,
  output logic [1:0]       m_rvalid_o,
  output logic [31:0]      m_rdata_o,
  output logic [1:0]       m_err_o,
  output logic             s_req_o,
  output logic             s_we_o,
  output logic [3:0]       s_be_o,
  output logic [31:0]      s_addr_o,
  output logic [31:0]      s_wdata_o,
  input  logic [31:0]      s_rdata_i
);

  logic       owner;
  logic [3:0] run;
  logic       rsp_vld;
  logic       rsp_id;
  logic       rsp_live;
  logic [1:0] gnt;
  logic       gnt_any;
  logic       gnt_id;
  logic       dec_err;

  // Owner keeps the bus under contention until it has used up its quantum.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      case (m_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (run < 4'(QUANTUM)) gnt = owner ? 2'b10 : 2'b01;
          else                   gnt = owner ? 2'b01 : 2'b10;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_any   = |gnt;
  assign gnt_id    = gnt[1];
  assign m_gnt_o   = gnt;

  assign s_req_o   = gnt_any & ~dec_err;
  assign s_we_o    = m_we_i[gnt_id];
  assign s_be_o    = m_be_i[gnt_id];
  assign s_addr_o  = m_addr_i[gnt_id];
  assign s_wdata_o = m_wdata_i[gnt_id];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner   <= 1'b0;
      run     <= 4'd0;
      rsp_vld <= 1'b0;
      rsp_id  <= 1'b0;
    end else begin
      rsp_vld <= gnt_any;
      rsp_id  <= gnt_id;
      if (gnt_any) begin
        if (gnt_id == owner) begin
          run <= (run == 4'hF) ? run : run + 4'd1;
        end else begin
          owner <= gnt_id;
          run   <= 4'd1;
        end
      end
    end
  end

  // A response still in flight when reset rises must never reach a master.
  assign rsp_live   = rsp_vld & ~rst_i;
  assign m_rvalid_o = {rsp_live & rsp_id, rsp_live & ~rsp_id};

`ifdef PERIPH_ARB_DECODE_ERR_EN
  logic rsp_err;

  assign dec_err = (m_addr_i[gnt_id][31:16] != BASE_ADDR[31:16]);

  always_ff @(posedge clk_i) begin
    if (rst_i) rsp_err <= 1'b0;
    else       rsp_err <= gnt_any & dec_err;
  end

  assign m_err_o   = m_rvalid_o & {2{rsp_err}};
  assign m_rdata_o = (rsp_live & ~rsp_err) ? s_rdata_i : 32'h0;
`else
  assign dec_err   = 1'b0;
  assign m_err_o   = 2'b00;
  assign m_rdata_o = rsp_live ? s_rdata_i : 32'h0;
`endif

endmodule

// File: tb/tb_periph_arb.sv
// Vector-table bench for periph_arb; responses are tracked with a scoreboard queue.
module tb_periph_arb;

`ifdef PERIPH_ARB_DECODE_ERR_EN
  localparam logic DEC = 1'b1;
`else
  localparam logic DEC = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] GOOD = 32'h0200_0010;
  localparam logic [31:0] WADR = 32'h0200_0004;
  localparam logic [31:0] BAD  = 32'h0300_0000;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [1:0]       m_req_i = '0;
  logic [1:0]       m_we_i = '0;
  logic [1:0][3:0]  m_be_i = {4'hC, 4'h3};
  logic [1:0][31:0] m_addr_i = '0;
  logic [1:0][31:0] m_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
  logic [1:0]       m_gnt_o;
  logic [1:0]       m_rvalid_o;
  logic [31:0]      m_rdata_o;
  logic [1:0]       m_err_o;
  logic             s_req_o;
  logic             s_we_o;
  logic [3:0]       s_be_o;
  logic [31:0]      s_addr_o;
  logic [31:0]      s_wdata_o;
  logic [31:0]      s_rdata_i = '0;

  periph_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] srd;
    logic [1:0]  gnt;
    logic        sreq;
    string       nm;
  } vec_t;

  typedef struct {
    logic id;
    logic err;
    logic rd;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] we,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] srd,
                              input logic [1:0] gnt, input logic sreq, input string nm);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
    v.srd = srd; v.gnt = gnt; v.sreq = sreq; v.nm = nm;
    return v;
  endfunction

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    rsp_t        r;
    logic [1:0]  exp_v;
    logic [31:0] sel;
    if (v.rst) begin
      sb.delete();
      compare({v.nm, "/rvalid"}, 32'(m_rvalid_o), 32'h0);
      compare({v.nm, "/err"},    32'(m_err_o),    32'h0);
      compare({v.nm, "/rdata"},  m_rdata_o,       32'h0);
    end else if (sb.size() > 0) begin
      r = sb.pop_front();
      exp_v = r.id ? 2'b10 : 2'b01;
      compare({v.nm, "/rvalid"}, 32'(m_rvalid_o), 32'(exp_v));
      compare({v.nm, "/err"},    32'(m_err_o),    r.err ? 32'(exp_v) : 32'h0);
      if (r.rd) compare({v.nm, "/rdata"}, m_rdata_o, r.err ? 32'h0 : v.srd);
    end else begin
      compare({v.nm, "/rvalid"}, 32'(m_rvalid_o), 32'h0);
    end
    compare({v.nm, "/gnt"},  32'(m_gnt_o), 32'(v.gnt));
    compare({v.nm, "/sreq"}, 32'(s_req_o), 32'(v.sreq));
    if (v.gnt != 2'b00) begin
      sel = v.gnt[1] ? v.a1 : v.a0;
      compare({v.nm, "/saddr"}, s_addr_o, sel);
      compare({v.nm, "/swe"},   32'(s_we_o), 32'(v.we[v.gnt[1]]));
      compare({v.nm, "/sbe"},   32'(s_be_o), v.gnt[1] ? 32'hC : 32'h3);
      if (v.we[v.gnt[1]]) compare({v.nm, "/swdata"}, s_wdata_o, v.gnt[1] ? 32'hBBBB_0001 : 32'hAAAA_0000);
      r.id  = v.gnt[1];
      r.err = DEC && (sel[31:16] != BASE[31:16]);
      r.rd  = ~v.we[v.gnt[1]];
      sb.push_back(r);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    rst_i       = v.rst;
    m_req_i     = v.req;
    m_we_i      = v.we;
    m_addr_i[0] = v.a0;
    m_addr_i[1] = v.a1;
    s_rdata_i   = v.srd;
    #2;
    checkOutput(v);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 2'b11, 2'b00, GOOD, GOOD, 32'h0, 2'b00, 0, "reset"));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 2'b11, 2'b00, GOOD, GOOD, 32'h100 + 32'(i),
                        (i >= 4 && i < 8) ? 2'b10 : 2'b01, 1, $sformatf("cont%0d", i)));
    vecs.push_back(mk(0, 2'b00, 2'b00, GOOD, GOOD, 32'h10A, 2'b00, 0, "cont_drain"));
    vecs.push_back(mk(0, 2'b10, 2'b00, GOOD, GOOD, 32'h0,   2'b10, 1, "pipe0"));
    vecs.push_back(mk(0, 2'b10, 2'b00, GOOD, GOOD, 32'hA,   2'b10, 1, "pipe1"));
    vecs.push_back(mk(0, 2'b10, 2'b00, GOOD, GOOD, 32'hB,   2'b10, 1, "pipe2"));
    vecs.push_back(mk(0, 2'b00, 2'b00, GOOD, GOOD, 32'hC,   2'b00, 0, "pipe_drain"));
    vecs.push_back(mk(0, 2'b01, 2'b01, WADR, GOOD, 32'h0,   2'b01, 1, "mix_wr0"));
    vecs.push_back(mk(0, 2'b10, 2'b00, WADR, GOOD, 32'h0,   2'b10, 1, "mix_rd1"));
    vecs.push_back(mk(0, 2'b00, 2'b00, WADR, GOOD, 32'h55,  2'b00, 0, "mix_drain"));
    vecs.push_back(mk(0, 2'b01, 2'b00, BAD,  GOOD, 32'h0,   2'b01, ~DEC, "dec_rd0"));
    vecs.push_back(mk(0, 2'b00, 2'b00, BAD,  GOOD, 32'h77,  2'b00, 0, "dec_drain"));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset landing on an in-flight response, then on a cycle with a pending request.
    applyStimulus(mk(0, 2'b01, 2'b00, GOOD, GOOD, 32'h0,  2'b01, 1, "mid_gnt"));
    applyStimulus(mk(1, 2'b00, 2'b00, GOOD, GOOD, 32'h99, 2'b00, 0, "mid_rst"));
    applyStimulus(mk(0, 2'b00, 2'b00, GOOD, GOOD, 32'h98, 2'b00, 0, "mid_post"));
    applyStimulus(mk(1, 2'b01, 2'b00, GOOD, GOOD, 32'h0,  2'b00, 0, "rst_req"));
    applyStimulus(mk(0, 2'b00, 2'b00, GOOD, GOOD, 32'h97, 2'b00, 0, "rst_req_post"));
    applyStimulus(mk(0, 2'b11, 2'b00, GOOD, GOOD, 32'h0,  2'b01, 1, "first_cont"));
    applyStimulus(mk(0, 2'b00, 2'b00, GOOD, GOOD, 32'h42, 2'b00, 0, "final_drain"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
